dir_cmd_gen: RTL and testbench

Front end for the ball controller. It turns four raw pushbuttons into clean, rate-limited direction strobes (up/down/left/right) that drive the position update logic. Stages: synchronise and debounce each button, resolve opposing presses, then emit move pulses with auto-repeat (first move immediate, then delay, then fixed-rate repeat).

---
 rtl/dir_cmd_pkg.sv | 31 +++
 rtl/dir_cmd_gen_debounce.sv | 41 ++++
 rtl/dir_cmd_gen.sv | 149 ++++++++++++++
 tb/tb_dir_cmd_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dir_cmd_pkg.sv
// Shared types and constants for the direction command generator:
// FSM state encoding, strobe-vector bit positions and default timing.
package dir_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 30000000;
   localparam int DEF_MOVE_PERIOD     = 1000000;
   localparam int DEF_TMR_W           = 25;

   // Opposing presses on an axis cancel that axis.
   function automatic logic [3:0] resolve_cancel(input logic [3:0] deb);
      logic [3:0] vec;
      vec[DIR_UP]    = deb[DIR_UP]    & ~deb[DIR_DOWN];
      vec[DIR_DOWN]  = deb[DIR_DOWN]  & ~deb[DIR_UP];
      vec[DIR_LEFT]  = deb[DIR_LEFT]  & ~deb[DIR_RIGHT];
      vec[DIR_RIGHT] = deb[DIR_RIGHT] & ~deb[DIR_LEFT];
      return vec;
   endfunction

endpackage

// File: rtl/dir_cmd_gen_debounce.sv
// One button: 2-FF synchroniser followed by a stability counter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce
   import dir_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_deb
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_deb;

   // Synchronise, then count consecutive cycles where the level differs from the accepted one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b00;
         r_cnt  <= '0;
         r_deb  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         if (r_sync[1] == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb <= r_sync[1];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_deb = r_deb;

endmodule

// File: rtl/dir_cmd_gen.sv
// Pushbutton front end: debounce, opposition resolve, auto-repeat move strobes.
// Optional build macro DIR_CMD_LAST_WINS_EN: last-pressed button of a pair wins.
module dir_cmd_gen
   import dir_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int MOVE_PERIOD     = DEF_MOVE_PERIOD,
   parameter int TMR_W           = DEF_TMR_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic [3:0] held,
   output logic       active
);

   logic [3:0]       w_btn;
   logic [3:0]       w_deb;
   logic [3:0]       w_vec;
   logic [3:0]       r_vec;
   state_t           r_state, w_state_nx;
   logic [TMR_W-1:0] r_tmr, w_tmr_nx;
   logic [3:0]       r_cur, w_cur_nx;
   logic [3:0]       r_strobe, w_strobe_nx;
   logic             r_active;

   assign w_btn = {btn_up, btn_down, btn_left, btn_right};

   for (genvar g = 0; g < 4; g++) begin : g_deb
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .i_btn (w_btn[g]),
         .o_deb (w_deb[g])
      );
   end

   assign held = w_deb;

`ifdef DIR_CMD_LAST_WINS_EN
   logic [3:0] r_deb_d;
   logic       r_last_ud, r_last_lr;
   logic [3:0] w_rise;
   logic       w_last_ud, w_last_lr;

   // A rise this cycle takes effect immediately so the vector is not a cycle stale.
   assign w_rise    = w_deb & ~r_deb_d;
   assign w_last_ud = w_rise[DIR_UP]   ? 1'b1 : (w_rise[DIR_DOWN]  ? 1'b0 : r_last_ud);
   assign w_last_lr = w_rise[DIR_LEFT] ? 1'b1 : (w_rise[DIR_RIGHT] ? 1'b0 : r_last_lr);

   assign w_vec[DIR_UP]    = w_deb[DIR_UP]    & (~w_deb[DIR_DOWN]  |  w_last_ud);
   assign w_vec[DIR_DOWN]  = w_deb[DIR_DOWN]  & (~w_deb[DIR_UP]    | ~w_last_ud);
   assign w_vec[DIR_LEFT]  = w_deb[DIR_LEFT]  & (~w_deb[DIR_RIGHT] |  w_last_lr);
   assign w_vec[DIR_RIGHT] = w_deb[DIR_RIGHT] & (~w_deb[DIR_LEFT]  | ~w_last_lr);

   // Remember which button of each axis was most recently accepted as pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb_d   <= 4'b0000;
         r_last_ud <= 1'b1;
         r_last_lr <= 1'b1;
      end else begin
         r_deb_d   <= w_deb;
         r_last_ud <= w_last_ud;
         r_last_lr <= w_last_lr;
      end
   end
`else
   assign w_vec = resolve_cancel(w_deb);
`endif

   // Next-state and strobe decode; r_cur is the vector last strobed, used to spot direction changes.
   always_comb begin
      w_state_nx  = r_state;
      w_tmr_nx    = r_tmr;
      w_cur_nx    = r_cur;
      w_strobe_nx = 4'b0000;
      case (r_state)
         IDLE: begin
            if (r_vec != 4'b0000) begin
               w_strobe_nx = r_vec;
               w_cur_nx    = r_vec;
               w_tmr_nx    = TMR_W'(REPEAT_DELAY - 1);
               w_state_nx  = DELAY;
            end else begin
               w_tmr_nx = TMR_W'(0);
               w_cur_nx = 4'b0000;
            end
         end
         DELAY, REPEAT: begin
            if (r_vec == 4'b0000) begin
               w_state_nx = IDLE;
               w_tmr_nx   = TMR_W'(0);
               w_cur_nx   = 4'b0000;
            end else if (r_vec != r_cur) begin
               w_strobe_nx = r_vec;
               w_cur_nx    = r_vec;
               w_tmr_nx    = TMR_W'(REPEAT_DELAY - 1);
               w_state_nx  = DELAY;
            end else if (r_tmr == TMR_W'(0)) begin
               w_strobe_nx = r_vec;
               w_tmr_nx    = TMR_W'(MOVE_PERIOD - 1);
               w_state_nx  = REPEAT;
            end else begin
               w_tmr_nx = r_tmr - TMR_W'(1);
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_tmr_nx   = TMR_W'(0);
            w_cur_nx   = 4'b0000;
         end
      endcase
   end

   // Pipeline register for the resolved vector plus FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec    <= 4'b0000;
         r_state  <= IDLE;
         r_tmr    <= TMR_W'(0);
         r_cur    <= 4'b0000;
         r_strobe <= 4'b0000;
         r_active <= 1'b0;
      end else begin
         r_vec    <= w_vec;
         r_state  <= w_state_nx;
         r_tmr    <= w_tmr_nx;
         r_cur    <= w_cur_nx;
         r_strobe <= w_strobe_nx;
         r_active <= (w_state_nx != IDLE);
      end
   end

   assign up     = r_strobe[DIR_UP];
   assign down   = r_strobe[DIR_DOWN];
   assign left   = r_strobe[DIR_LEFT];
   assign right  = r_strobe[DIR_RIGHT];
   assign active = r_active;

endmodule

// File: tb/tb_dir_cmd_gen.sv
// Scoreboard bench for dir_cmd_gen: expected strobes (edge offset, vector) are queued
// when buttons are driven and compared against strobes captured from the DUT.
module tb_dir_cmd_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       up, down, left, right, active;
   logic [3:0] held;

   int          cyc = 0;
   int          t0 = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];

   dir_cmd_gen #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (20),
      .MOVE_PERIOD     (8),
      .TMR_W           (25)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .held      (held),
      .active    (active)
   );

   always #5 clk = ~clk;

   // Advance n edges, recording every strobe as {edge offset from t0, vector}.
   task automatic collect(input int n);
      logic [31:0] v;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         #1;
         if ({up, down, left, right} != 4'b0000) begin
            v = 32'(cyc - t0);
            v = (v << 4) | {28'd0, up, down, left, right};
            obs_q.push_back(v);
         end
      end
   endtask

   task automatic expect_strobe(input int rel, input logic [3:0] vec);
      logic [31:0] v;
      v = 32'(rel);
      exp_q.push_back((v << 4) | {28'd0, vec});
   endtask

   // Next edge sampled becomes edge 0 of the scenario.
   task automatic mark_edge0();
      t0 = cyc + 1;
   endtask

   task automatic do_reset();
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      rst_n = 1'b0;
      collect(3);
      rst_n = 1'b1;
      collect(2);
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      mark_edge0();
      btn_up = 1'b1;
      collect(12);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({up, down, left, right, held, active} !== 9'd0) begin
         n_err++;
         $display("FAIL reset_async: outputs %b, want 000000000", {up, down, left, right, held, active});
      end
      btn_up = 1'b0;
      collect(2);
      rst_n = 1'b1;
      obs_q.delete();
      collect(100);
      n_cmp++;
      if (obs_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_quiet: %0d strobes after reset, want 0", obs_q.size());
      end
      n_cmp++;
      if (active !== 1'b0) begin
         n_err++;
         $display("FAIL reset_active: active %b, want 0", active);
      end
      obs_q.delete();
   endtask

   task automatic test_hold_repeat();
      logic [31:0] e, o;
      mark_edge0();
      btn_up = 1'b1;
      expect_strobe(7, 4'b1000);
      expect_strobe(27, 4'b1000);
      expect_strobe(35, 4'b1000);
      expect_strobe(43, 4'b1000);
      collect(7);
      n_cmp++;
      if (active !== 1'b0) begin n_err++; $display("FAIL hold_active_e6: active %b, want 0", active); end
      collect(1);
      n_cmp++;
      if (active !== 1'b1) begin n_err++; $display("FAIL hold_active_e7: active %b, want 1", active); end
      collect(36);
      btn_up = 1'b0;
      collect(20);
      n_cmp++;
      if (active !== 1'b0) begin n_err++; $display("FAIL hold_release_active: active %b, want 0", active); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL hold_repeat: missing strobe edge %0d vec %b", e >> 4, e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_err++;
               $display("FAIL hold_repeat: got edge %0d vec %b, want edge %0d vec %b", o >> 4, o[3:0], e >> 4, e[3:0]);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin n_err++; $display("FAIL hold_repeat_extra: %0d extra strobes, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_glitch();
      mark_edge0();
      for (int i = 0; i < 50; i++) begin
         btn_right = ~btn_right;
         collect(1);
         n_cmp++;
         if (held[0] !== 1'b0) begin n_err++; $display("FAIL glitch_held: cycle %0d held[0] %b, want 0", i, held[0]); end
      end
      btn_right = 1'b0;
      collect(10);
      n_cmp++;
      if (obs_q.size() != 0) begin n_err++; $display("FAIL glitch_strobe: %0d strobes, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_opposing();
      logic [31:0] e, o;
      mark_edge0();
      btn_up = 1'b1;
      btn_down = 1'b1;
      collect(8);
      n_cmp++;
      if (held !== 4'b1100) begin n_err++; $display("FAIL opposing_held: held %b, want 1100", held); end
`ifdef DIR_CMD_LAST_WINS_EN
      expect_strobe(7, 4'b1000);
      btn_down = 1'b0;
      collect(7);
      btn_down = 1'b1;
      expect_strobe(22, 4'b0100);
      expect_strobe(42, 4'b0100);
      expect_strobe(50, 4'b0100);
      collect(38);
`else
      collect(30);
`endif
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL opposing: missing strobe edge %0d vec %b", e >> 4, e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_err++;
               $display("FAIL opposing: got edge %0d vec %b, want edge %0d vec %b", o >> 4, o[3:0], e >> 4, e[3:0]);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin n_err++; $display("FAIL opposing_extra: %0d extra strobes, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_diagonal();
      logic [31:0] e, o;
      mark_edge0();
      btn_up = 1'b1;
      expect_strobe(7, 4'b1000);
      collect(15);
      btn_left = 1'b1;
      expect_strobe(22, 4'b1010);
      expect_strobe(42, 4'b1010);
      expect_strobe(50, 4'b1010);
      expect_strobe(58, 4'b1010);
      collect(45);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL diagonal: missing strobe edge %0d vec %b", e >> 4, e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_err++;
               $display("FAIL diagonal: got edge %0d vec %b, want edge %0d vec %b", o >> 4, o[3:0], e >> 4, e[3:0]);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin n_err++; $display("FAIL diagonal_extra: %0d extra strobes, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_short_press();
      logic [31:0] e, o;
      mark_edge0();
      btn_left = 1'b1;
      collect(3);
      btn_left = 1'b0;
      collect(20);
      n_cmp++;
      if (obs_q.size() != 0) begin n_err++; $display("FAIL short3_strobe: %0d strobes, want 0", obs_q.size()); end
      obs_q.delete();
      mark_edge0();
      btn_left = 1'b1;
      expect_strobe(7, 4'b0010);
      collect(10);
      btn_left = 1'b0;
      collect(30);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL short10: missing strobe edge %0d vec %b", e >> 4, e[3:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_err++;
               $display("FAIL short10: got edge %0d vec %b, want edge %0d vec %b", o >> 4, o[3:0], e >> 4, e[3:0]);
            end
         end
      end
      n_cmp++;
      if (obs_q.size() != 0) begin n_err++; $display("FAIL short10_extra: %0d extra strobes, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   initial begin
      do_reset();
      test_reset();
      do_reset();
      test_hold_repeat();
      do_reset();
      test_glitch();
      do_reset();
      test_opposing();
      do_reset();
      test_diagonal();
      do_reset();
      test_short_press();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
